// File: rtl/tsg_phase_monitor.sv
// Receive-side checker for the 8-phase one-hot timing bus: decodes the phase,
// acquires/holds lock, flywheels over isolated glitches and counts errors.
module tsg_phase_monitor #(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic [7:0]       T,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             frame_pulse,
    output logic             onehot_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             frame_d, oh_err_d, seq_err_d, err_any;
    logic [ERR_W-1:0] cnt_d;

    logic             is_onehot, is_good;
    logic [2:0]       idx;

    // Priority encoder is only meaningful when T is one-hot; is_onehot gates its use.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (T[i]) idx = 3'(i);
        end
    end

    assign is_onehot = (T != 8'd0) && ((T & (T - 8'd1)) == 8'd0);
    assign is_good   = is_onehot && (idx == prev_q + 3'd1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        prev_d    = prev_q;
        good_d    = good_q;
        bad_d     = bad_q;
        frame_d   = 1'b0;
        oh_err_d  = 1'b0;
        seq_err_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (is_onehot) begin
                    prev_d  = idx;
                    good_d  = 4'd0;
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (is_good) begin
                    prev_d = idx;
                    good_d = good_q + 4'd1;
                    if (good_d == LOCK_N) begin
                        state_d = LOCKED;
                        bad_d   = 4'd0;
                    end
                end else if (is_onehot) begin
                    seq_err_d = 1'b1;
                    prev_d    = idx;
                    good_d    = 4'd0;
                end else begin
                    oh_err_d = 1'b1;
                    state_d  = HUNT;
                end
            end
            LOCKED: begin
                if (is_good) begin
                    prev_d  = idx;
                    bad_d   = 4'd0;
                    frame_d = (idx == 3'd0);
                end else begin
                    // Flywheel: assume the expected phase arrived so one glitch costs one error.
                    oh_err_d  = ~is_onehot;
                    seq_err_d = is_onehot;
                    prev_d    = prev_q + 3'd1;
                    bad_d     = bad_q + 4'd1;
                    if (bad_d == UNLOCK_N) state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
                prev_d  = 3'd0;
                good_d  = 4'd0;
                bad_d   = 4'd0;
            end
        endcase
    end

    assign err_any = oh_err_d | seq_err_d;

    always_comb begin
        cnt_d = err_count;
        if (err_clr)
            cnt_d = err_any ? ERR_W'(1) : '0;
        else if (err_any && (err_count != '1))
            cnt_d = err_count + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!sync_reset_n) begin
            state_q     <= HUNT;
            prev_q      <= 3'd0;
            good_q      <= 4'd0;
            bad_q       <= 4'd0;
            phase       <= 3'd0;
            frame_pulse <= 1'b0;
            onehot_err  <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            phase       <= (state_d == HUNT) ? 3'd0 : prev_d;
            frame_pulse <= frame_d;
            onehot_err  <= oh_err_d;
            seq_err     <= seq_err_d;
            err_count   <= cnt_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign phase_valid = locked;

endmodule
